// File: rtl/data_mem_arbiter_pkg.sv
// mem_arb_pkg: shared constants and types for the data-memory arbiter.
//   PORT_CPU / PORT_AUX : port indices used as grant identifiers
//   DM_AW / DM_DW       : data-memory address and data widths
package mem_arb_pkg;

    localparam int DM_AW = 8;
    localparam int DM_DW = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef logic [DM_AW-1:0] dmAddr_t;
    typedef logic [DM_DW-1:0] dmData_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one master's request/response channel into the arbiter.
//   req   : request, held until ack
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write data
//   ack   : one-cycle completion pulse (from arbiter)
//   rdata : registered read data (from arbiter)
interface data_mem_arbiter_if;
    import mem_arb_pkg::*;

    logic    req;
    logic    we;
    dmAddr_t addr;
    dmData_t wdata;
    logic    ack;
    dmData_t rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);

    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: two-request arbiter with a last-grant register.
//   clk, rst : clock, synchronous active-high reset
//   elig     : eligible requests, bit n = port n
//   gntVld   : a port is granted this cycle
//   gntIdx   : index of the granted port (valid with gntVld)
// FIXED_PRIO = 0 gives round-robin on ties, 1 lets port 0 always win.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    output logic       gntVld,
    output logic       gntIdx
);

    logic lastGrant;

    always_comb begin
        gntVld = |elig;
        gntIdx = PORT_CPU;
        if (elig == 2'b10) begin
            gntIdx = PORT_AUX;
        end else if (elig == 2'b11) begin
            // On a tie round-robin hands the grant to the port that did not win last.
            gntIdx = (FIXED_PRIO != 0) ? PORT_CPU : ~lastGrant;
        end
    end

    // Resetting to PORT_AUX makes port 0 win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant <= PORT_AUX;
        end else if (gntVld) begin
            lastGrant <= gntIdx;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port 256x8 data memory between the CPU
// load/store path (port0) and a secondary master (port1).
//   clk, rst  : clock, synchronous active-high reset
//   port0/1   : master channels (req/we/addr/wdata in, ack/rdata out)
//   mem_addr  : memory address from the granted port (0 when idle)
//   mem_din   : memory write data from the granted port (0 when idle)
//   mem_rd    : granted transaction is a read
//   mem_wr    : granted transaction is a write
//   mem_dout  : memory combinational read data
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    data_mem_arbiter_if.slave        port0,
    data_mem_arbiter_if.slave        port1,
    output dmAddr_t                  mem_addr,
    output dmData_t                  mem_din,
    output logic                     mem_rd,
    output logic                     mem_wr,
    input  dmData_t                  mem_dout
);

    logic       ack0Q;
    logic       ack1Q;
    dmData_t    rdata0Q;
    dmData_t    rdata1Q;
    logic [1:0] elig;
    logic       gntVld;
    logic       gntIdx;
    logic       gntWe;

    // A port whose ack is high this cycle is masked so its held request is
    // not served a second time.
    assign elig = {port1.req & ~ack1Q, port0.req & ~ack0Q};

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) uArb (
        .clk    (clk),
        .rst    (rst),
        .elig   (elig),
        .gntVld (gntVld),
        .gntIdx (gntIdx)
    );

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        gntWe    = 1'b0;
        if (gntVld) begin
            if (gntIdx == PORT_AUX) begin
                mem_addr = port1.addr;
                mem_din  = port1.wdata;
                gntWe    = port1.we;
            end else begin
                mem_addr = port0.addr;
                mem_din  = port0.wdata;
                gntWe    = port0.we;
            end
        end
        mem_wr = gntVld & gntWe;
        mem_rd = gntVld & ~gntWe;
    end

    // Completion: ack pulses for the granted port, read data is captured on
    // the same edge the memory would take a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0Q   <= 1'b0;
            ack1Q   <= 1'b0;
            rdata0Q <= '0;
            rdata1Q <= '0;
        end else begin
            ack0Q <= gntVld && (gntIdx == PORT_CPU);
            ack1Q <= gntVld && (gntIdx == PORT_AUX);
            if (gntVld && !gntWe) begin
                if (gntIdx == PORT_AUX) begin
                    rdata1Q <= mem_dout;
                end else begin
                    rdata0Q <= mem_dout;
                end
            end
        end
    end

    assign port0.ack   = ack0Q;
    assign port1.ack   = ack1Q;
    assign port0.rdata = rdata0Q;
    assign port1.rdata = rdata1Q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: drives a round-robin instance (A) and a fixed-priority
// instance (B) with the same directed vectors, each attached to its own 256x8
// memory, and checks both against a transaction-level model every cycle.
module tb_data_mem_arbiter;

    logic clk;
    logic rst;

    logic       r0, w0, r1, w1;
    logic [7:0] a0, d0, a1, d1;

    data_mem_arbiter_if ifA0 ();
    data_mem_arbiter_if ifA1 ();
    data_mem_arbiter_if ifB0 ();
    data_mem_arbiter_if ifB1 ();

    assign ifA0.req = r0; assign ifA0.we = w0; assign ifA0.addr = a0; assign ifA0.wdata = d0;
    assign ifA1.req = r1; assign ifA1.we = w1; assign ifA1.addr = a1; assign ifA1.wdata = d1;
    assign ifB0.req = r0; assign ifB0.we = w0; assign ifB0.addr = a0; assign ifB0.wdata = d0;
    assign ifB1.req = r1; assign ifB1.we = w1; assign ifB1.addr = a1; assign ifB1.wdata = d1;

    logic [7:0] addrA, dinA, doutA, addrB, dinB, doutB;
    logic       rdA, wrA, rdB, wrB;
    logic [7:0] memA [256];
    logic [7:0] memB [256];

    data_mem_arbiter #(.FIXED_PRIO(0)) dutA (
        .clk(clk), .rst(rst), .port0(ifA0), .port1(ifA1),
        .mem_addr(addrA), .mem_din(dinA), .mem_rd(rdA), .mem_wr(wrA), .mem_dout(doutA)
    );

    data_mem_arbiter #(.FIXED_PRIO(1)) dutB (
        .clk(clk), .rst(rst), .port0(ifB0), .port1(ifB1),
        .mem_addr(addrB), .mem_din(dinB), .mem_rd(rdB), .mem_wr(wrB), .mem_dout(doutB)
    );

    assign doutA = memA[addrA];
    assign doutB = memB[addrB];

    function automatic logic [7:0] initVal(input int i);
        return 8'(i) ^ 8'hA5;
    endfunction

    // Memories: preload, then write on the edge when strobed.
    initial begin
        for (int i = 0; i < 256; i++) begin
            memA[i] = initVal(i);
            memB[i] = initVal(i);
        end
        forever begin
            @(posedge clk);
            if (wrA) memA[addrA] <= dinA;
            if (wrB) memB[addrB] <= dinB;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Observed outputs per instance: bus = {rd, wr, addr, din}, ports = {ack0, ack1, rdata0, rdata1}.
    logic [17:0] busAct  [2];
    logic [17:0] portAct [2];
    assign busAct[0]  = {rdA, wrA, addrA, dinA};
    assign busAct[1]  = {rdB, wrB, addrB, dinB};
    assign portAct[0] = {ifA0.ack, ifA1.ack, ifA0.rdata, ifA1.rdata};
    assign portAct[1] = {ifB0.ack, ifB1.ack, ifB0.rdata, ifB1.rdata};

    // Reference model: which transaction completes on each edge, kept as
    // per-instance expected acks, read data, last winner and memory image.
    logic [7:0] shadow [2][256];
    bit         eAck   [2][2];
    logic [7:0] eRd    [2][2];
    bit         eLast  [2];
    bit         gv [2], gi [2], gw [2];
    logic [7:0] ga [2], gd [2];

    initial begin : model
        bit el0, el1;
        logic [17:0] expBus, expPort;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) shadow[k][i] = initVal(i);
            eAck[k][0] = 0; eAck[k][1] = 0;
            eRd[k][0] = 8'h00; eRd[k][1] = 8'h00;
            eLast[k] = 1; gv[k] = 0; gi[k] = 0; gw[k] = 0; ga[k] = 8'h00; gd[k] = 8'h00;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (gv[k] && gw[k]) shadow[k][ga[k]] = gd[k];
                if (rst) begin
                    eAck[k][0] = 0; eAck[k][1] = 0;
                    eRd[k][0] = 8'h00; eRd[k][1] = 8'h00;
                    eLast[k] = 1;
                end else begin
                    eAck[k][0] = gv[k] && !gi[k];
                    eAck[k][1] = gv[k] && gi[k];
                    if (gv[k] && !gw[k]) eRd[k][gi[k]] = shadow[k][ga[k]];
                    if (gv[k]) eLast[k] = gi[k];
                end
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                el0 = r0 && !eAck[k][0];
                el1 = r1 && !eAck[k][1];
                gv[k] = el0 || el1;
                if (el0 && el1) gi[k] = (k == 1) ? 1'b0 : !eLast[k];
                else            gi[k] = !el0;
                gw[k] = gi[k] ? w1 : w0;
                ga[k] = gi[k] ? a1 : a0;
                gd[k] = gi[k] ? d1 : d0;
                expBus  = gv[k] ? {!gw[k], gw[k], ga[k], gd[k]} : 18'h0;
                expPort = {eAck[k][0], eAck[k][1], eRd[k][0], eRd[k][1]};
                check($sformatf("%s_bus", k ? "fp" : "rr"), 32'(busAct[k]), 32'(expBus));
                check($sformatf("%s_port", k ? "fp" : "rr"), 32'(portAct[k]), 32'(expPort));
            end
        end
    end

    // One cycle of stimulus; returns 1 time unit after the edge that samples it.
    task automatic cyc(input logic q0, input logic e0, input logic [7:0] x0, input logic [7:0] y0,
                       input logic q1, input logic e1, input logic [7:0] x1, input logic [7:0] y1);
        r0 = q0; w0 = e0; a0 = x0; d0 = y0;
        r1 = q1; w1 = e1; a1 = x1; d1 = y1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin : stim
        rst = 1'b1;
        r0 = 0; w0 = 0; a0 = 8'h00; d0 = 8'h00;
        r1 = 0; w1 = 0; a1 = 8'h00; d1 = 8'h00;
        idle(2);
        check("rr_reset", 32'(portAct[0]), 32'h0);
        check("fp_reset", 32'(portAct[1]), 32'h0);
        rst = 1'b0;

        // Single port: write 0x5A to 0x10, then read it back.
        cyc(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00);
        check("rr_wr_ack", 32'(portAct[0][17:16]), 32'h2);
        check("fp_wr_ack", 32'(portAct[1][17:16]), 32'h2);
        idle(1);
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        check("rr_rd_ack", 32'(portAct[0][17:16]), 32'h2);
        check("rr_rd_data", 32'(portAct[0][15:8]), 32'h5A);
        check("fp_rd_data", 32'(portAct[1][15:8]), 32'h5A);
        idle(1);

        // Both ports saturated with reads straight after reset.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        cyc(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        check("rr_tie1", 32'(portAct[0][17:16]), 32'h2);
        check("fp_tie1", 32'(portAct[1][17:16]), 32'h2);
        cyc(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        check("rr_tie2", 32'(portAct[0][17:16]), 32'h1);
        check("fp_tie2", 32'(portAct[1][17:16]), 32'h1);
        check("rr_tie2_rd1", 32'(portAct[0][7:0]), 32'h85);
        for (int i = 0; i < 14; i++) cyc(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        idle(1);

        // Cross-port coherence after port 0 won last: round-robin serves the
        // port 1 write first, fixed priority serves the port 0 read first.
        cyc(1, 1, 8'h30, 8'h11, 0, 0, 8'h00, 8'h00);
        idle(1);
        cyc(1, 0, 8'hFF, 8'h00, 1, 1, 8'hFF, 8'hC3);
        check("rr_coh_ack", 32'(portAct[0][17:16]), 32'h1);
        check("fp_coh_ack", 32'(portAct[1][17:16]), 32'h2);
        check("fp_coh_old", 32'(portAct[1][15:8]), 32'h5A);
        cyc(1, 0, 8'hFF, 8'h00, 1, 1, 8'hFF, 8'hC3);
        check("rr_coh_new", 32'(portAct[0][15:8]), 32'hC3);
        check("fp_coh_ack2", 32'(portAct[1][17:16]), 32'h1);
        idle(1);

        // Reset while a grant is on the bus.
        rst = 1'b1;
        cyc(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        check("rr_rst_mid", 32'(portAct[0]), 32'h0);
        check("fp_rst_mid", 32'(portAct[1]), 32'h0);
        rst = 1'b0;
        cyc(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        check("rr_rst_tie", 32'(portAct[0][17:8]), 32'h25A);
        check("fp_rst_tie", 32'(portAct[1][17:8]), 32'h25A);
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        check("rr_rst_p1", 32'(portAct[0][17:16]), 32'h1);

        // Idle: no strobes, read data held.
        idle(11);
        check("rr_idle_rd", 32'(portAct[0][15:0]), 32'h5A85);
        check("fp_idle_rd", 32'(portAct[1][15:0]), 32'h5A85);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
